lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-cycle RV32I core. Consumes the `lsu_VALID`/`lsu_READY` handshake from the control decoder, where `o_pc_en` stalls the PC while `lsu_VALID & ~lsu_READY`. Turns each load/store into one word-aligned access on a variable-latency memory bus. Handles byte-lane steering, write strobes, load sign/zero extension, misalignment detection and a bus timeout.

## Interface
Parameters:
- `TIMEOUT_CYC`, 255: maximum cycles in REQ waiting for `i_mem_ack` before a bus error is flagged; must be ≥1.

Ports:
- `i_clk`  in  1  clock, all state on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `lsu_VALID`  in  1  request from control; held high until `lsu_READY`.
- `lsu_READY`  out  1  access complete; high for exactly one cycle.
- `i_st_mem`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  `inst[14:12]`: B=000, H=001, W=010, BU=100, HU=101.
- `i_addr`  in  32  effective address (ALU result).
- `i_st_data`  in  32  rs2 value for stores.
- `o_ld_data`  out  32  extended load result; valid while `lsu_READY`.
- `o_misaligned`  out  1  with `lsu_READY`: H at odd address, or W with `addr[1:0]≠0`.
- `o_bus_err`  out  1  with `lsu_READY`: timeout expired.
- `o_mem_req`  out  1  bus request, held until ack.
- `o_mem_we`  out  1  write enable.
- `o_mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  32  lane-replicated store data.
- `i_mem_ack`  in  1  single-cycle completion; read data valid the same cycle.
- `i_mem_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On `lsu_VALID`, register addr, funct3, store flag and data.
  - If misaligned: go to DONE with `o_misaligned=1`. No bus access and no write.
  - Otherwise: go to REQ with the counter cleared.
- REQ:
  - `o_mem_req=1`; addr/we/be/wdata are stable from the registers.
  - On `i_mem_ack`: capture rdata and go to DONE.
  - Otherwise, when the counter reaches `TIMEOUT_CYC-1`: go to DONE with `o_bus_err=1`. The request drops.
- DONE:
  - `lsu_READY=1` and the outputs are valid; always return to IDLE.
  - `lsu_VALID` is not re-sampled in DONE, so the same instruction never issues twice.
- Byte enables:
  - B: `4'b0001<<addr[1:0]`.
  - H: `4'b0011<<{addr[1],1'b0}`.
  - W: `4'b1111`.
  - Loads drive `be` the same way.
- Store data:
  - B: byte replicated ×4.
  - H: half replicated ×2.
  - W: as-is.
- Load data:
  - Select the byte/half by `addr[1:0]`.
  - Sign-extend when `funct3[2]=0`, zero-extend when `funct3[2]=1`.
  - On misaligned or bus error, `o_ld_data=0`.
- funct3 011/11x: treated as W (decoder never issues them).
- `i_mem_ack` outside REQ is ignored.
- `lsu_VALID` dropping during REQ is a protocol violation. The access still completes and the result is discarded.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - All outputs 0: `lsu_READY`, `o_mem_req`, `o_mem_we`, `o_mem_be`, `o_mem_addr`, `o_mem_wdata`, `o_ld_data`, `o_misaligned`, `o_bus_err`.
- Reset mid-REQ drops `o_mem_req` the next cycle. Any pending ack is ignored.
- Latency from `lsu_VALID` rising (cycle 0):
  - `o_mem_req` rises in cycle 1.
  - With ack in cycle k≥1, `lsu_READY` is high in cycle k+1.
  - Zero-wait memory therefore gives READY in cycle 2, i.e. 3 cycles per load/store.
- Misaligned: READY in cycle 1.
- Timeout: READY in cycle `TIMEOUT_CYC+1`.
- Back-to-back: a new `lsu_VALID` seen in the IDLE cycle after DONE starts the next access.
- All bus outputs are registered. Only `lsu_READY` decodes state.

## Structure
- `singlecycle_pkg` holds:
  - `LsuState_e` (IDLE/REQ/DONE).
  - `LsuSize_e` (LS_B/LS_H/LS_W/LS_BU/LS_HU, 3-bit funct3 values).
- Sub-module `lsu_align` (combinational): funct3 + addr[1:0] + st_data/rdata → be, wdata, extended load data, misaligned.
- Top `lsu` holds the FSM, registers and timeout counter.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, ack in cycle 1 → `o_mem_addr=0x100`, `be=1111`, `lsu_READY` in cycle 2, `o_ld_data=0xDEADBEEF`.
- LB addr 0x103, rdata 0x80FF_FFFF → `be=1000`, `o_ld_data=0xFFFFFF80`. LBU → `0x00000080`. LHU addr 0x102 → `0x000080FF`.
- SB addr 0x201, st_data 0x12345678 → `we=1`, `be=0010`, `wdata=0x78787878`, `o_mem_addr=0x200`. SH addr 0x202 → `be=1100`, `wdata=0x56785678`.
- SW addr 0x302 → `o_misaligned=1` with READY in cycle 1, `o_mem_req` never asserted.
- `TIMEOUT_CYC=4`, no ack → req high cycles 1–4, READY with `o_bus_err=1` in cycle 5, `o_ld_data=0`.
- Reset asserted in cycle 2 of a 5-wait access → req low next cycle, state IDLE, late ack ignored. A new LW then completes normally.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// Shared types for the single-cycle RV32I core: LSU FSM states and
// load/store size encodings taken straight from inst[14:12].
package singlecycle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } LsuState_e;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } LsuSize_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: write strobes, replicated store data,
// extended load data and misalignment detection. Purely combinational.
module lsu_align
   import singlecycle_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [31:0] shifted_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign shifted_s = rdata >> {addr_lo, 3'b000};
   assign byte_s    = shifted_s[7:0];
   assign half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   // Size decode; unused encodings (011, 11x) fall through to word
   always_comb begin
      be         = 4'b1111;
      wdata      = st_data;
      ld_data    = rdata;
      misaligned = (addr_lo != 2'b00);
      case (funct3)
         LS_B, LS_BU: begin
            be         = 4'b0001 << addr_lo;
            wdata      = {4{st_data[7:0]}};
            misaligned = 1'b0;
            if (funct3[2]) begin
               ld_data = {24'd0, byte_s};
            end else begin
               ld_data = {{24{byte_s[7]}}, byte_s};
            end
         end
         LS_H, LS_HU: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata      = {2{st_data[15:0]}};
            misaligned = addr_lo[0];
            if (funct3[2]) begin
               ld_data = {16'd0, half_s};
            end else begin
               ld_data = {{16{half_s[15]}}, half_s};
            end
         end
         default: begin
            be         = 4'b1111;
            wdata      = st_data;
            ld_data    = rdata;
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one lsu_VALID request into a single word-aligned
// access on a variable-latency bus, with misalignment trap and bus timeout.
module lsu
   import singlecycle_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 32'd255
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        lsu_VALID,
   output logic        lsu_READY,
   input  logic        i_st_mem,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_ld_data,
   output logic        o_misaligned,
   output logic        o_bus_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

   LsuState_e        state_r, next_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       addr_lo_r;
   logic [2:0]       funct3_r;
   logic             st_r;
   logic [31:0]      st_data_r;
   logic             mem_req_r, mem_we_r;
   logic [31:0]      mem_addr_r, mem_wdata_r, ld_data_r;
   logic [3:0]       mem_be_r;
   logic             misaligned_r, bus_err_r;

   logic             launch_s, trap_s, ack_done_s, timeout_s;
   logic [2:0]       al_funct3_s;
   logic [1:0]       al_addr_lo_s;
   logic [31:0]      al_st_data_s, al_wdata_s, al_ld_data_s;
   logic [3:0]       al_be_s;
   logic             al_mis_s;

   // In IDLE the aligner looks at the live request; afterwards at the captured one
   assign al_funct3_s  = (state_r == IDLE) ? i_funct3       : funct3_r;
   assign al_addr_lo_s = (state_r == IDLE) ? i_addr[1:0]    : addr_lo_r;
   assign al_st_data_s = (state_r == IDLE) ? i_st_data      : st_data_r;

   lsu_align u_align (
      .funct3     (al_funct3_s),
      .addr_lo    (al_addr_lo_s),
      .st_data    (al_st_data_s),
      .rdata      (i_mem_rdata),
      .be         (al_be_s),
      .wdata      (al_wdata_s),
      .ld_data    (al_ld_data_s),
      .misaligned (al_mis_s)
   );

   // Next-state decode and transition qualifiers
   always_comb begin
      next_state_s = state_r;
      launch_s     = 1'b0;
      trap_s       = 1'b0;
      ack_done_s   = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (lsu_VALID) begin
               if (al_mis_s) begin
                  next_state_s = DONE;
                  trap_s       = 1'b1;
               end else begin
                  next_state_s = REQ;
                  launch_s     = 1'b1;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         REQ: begin
            if (i_mem_ack) begin
               next_state_s = DONE;
               ack_done_s   = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
               next_state_s = DONE;
               timeout_s    = 1'b1;
            end else begin
               next_state_s = REQ;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, counter, captured request, bus outputs and result registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         addr_lo_r    <= 2'b00;
         funct3_r     <= 3'b000;
         st_r         <= 1'b0;
         st_data_r    <= 32'd0;
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= 32'd0;
         mem_be_r     <= 4'b0000;
         mem_wdata_r  <= 32'd0;
         ld_data_r    <= 32'd0;
         misaligned_r <= 1'b0;
         bus_err_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if ((state_r == REQ) && (next_state_s == REQ)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= {CNT_W{1'b0}};
         end
         if ((state_r == IDLE) && lsu_VALID) begin
            addr_lo_r <= i_addr[1:0];
            funct3_r  <= i_funct3;
            st_r      <= i_st_mem;
            st_data_r <= i_st_data;
         end
         if (launch_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= i_st_mem;
            mem_addr_r  <= {i_addr[31:2], 2'b00};
            mem_be_r    <= al_be_s;
            mem_wdata_r <= al_wdata_s;
         end else if ((state_r == REQ) && (next_state_s != REQ)) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'd0;
         end
         // Result flags live only for the DONE cycle
         misaligned_r <= trap_s;
         bus_err_r    <= timeout_s;
         ld_data_r    <= (ack_done_s && !st_r) ? al_ld_data_s : 32'd0;
      end
   end

   assign lsu_READY    = (state_r == DONE);
   assign o_ld_data    = ld_data_r;
   assign o_misaligned = misaligned_r;
   assign o_bus_err    = bus_err_r;
   assign o_mem_req    = mem_req_r;
   assign o_mem_we     = mem_we_r;
   assign o_mem_addr   = mem_addr_r;
   assign o_mem_be     = mem_be_r;
   assign o_mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases followed by random accesses
// compared against a byte-level reference model.
module tb_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_VALID, lsu_READY, st_mem;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data, ld_data;
   logic        misaligned, bus_err, mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_tests = 0;
   int n_fail  = 0;

   lsu #(.TIMEOUT_CYC(TMO)) dut (
      .i_clk(clk), .i_rst(rst), .lsu_VALID(lsu_VALID), .lsu_READY(lsu_READY),
      .i_st_mem(st_mem), .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
      .o_ld_data(ld_data), .o_misaligned(misaligned), .o_bus_err(bus_err),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
      .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Access size in bytes: 1, 2 or 4 (unused encodings behave as words)
   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
      return (a % size_of(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      int off = (a % 4) - ((a % 4) % sz);
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      int sz = size_of(f3);
      logic [31:0] w = 32'd0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
      int sz = size_of(f3);
      int off = (a % 4) - ((a % 4) % sz);
      longint v = (r >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
      if (sz < 4 && f3[2] == 1'b0 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      return v[31:0];
   endfunction

   // One access starting in the current (IDLE) cycle; k = ack cycle, 0 = never
   task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int k, input logic [31:0] rd,
                             output logic [31:0] o_ld, output logic [3:0] o_be,
                             output logic [31:0] o_wd, output logic [31:0] o_ad);
      logic mis = m_mis(f3, a);
      int   done_c;
      logic err;
      o_ld = 32'd0; o_be = 4'd0; o_wd = 32'd0; o_ad = 32'd0;
      lsu_VALID = 1'b1; st_mem = st; funct3 = f3; addr = a; st_data = sd;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      err    = !mis && !(k >= 1 && k <= TMO);
      done_c = mis ? 1 : (err ? TMO + 1 : k + 1);
      for (int c = 1; c <= done_c; c++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (c < done_c) begin
            chk_eq("ready_early", {31'd0, lsu_READY}, 32'd0);
            chk_eq("req_held", {31'd0, mem_req}, 32'd1);
            chk_eq("be", {28'd0, mem_be}, {28'd0, m_be(f3, a)});
            if (c == 1) begin
               o_be = mem_be; o_wd = mem_wdata; o_ad = mem_addr;
               chk_eq("we", {31'd0, mem_we}, {31'd0, st});
               chk_eq("addr", mem_addr, {a[31:2], 2'b00});
               if (st) chk_eq("wdata", mem_wdata, m_wdata(f3, sd));
            end
            if (c == k) begin
               mem_ack = 1'b1; mem_rdata = rd;
            end
         end else begin
            o_ld = ld_data;
            chk_eq("ready", {31'd0, lsu_READY}, 32'd1);
            chk_eq("req_done", {31'd0, mem_req}, 32'd0);
            chk_eq("mis", {31'd0, misaligned}, {31'd0, mis});
            chk_eq("bus_err", {31'd0, bus_err}, {31'd0, err});
            if (!st || mis || err)
               chk_eq("ld_data", ld_data, (mis || err) ? 32'd0 : m_ld(f3, a, rd));
         end
      end
      lsu_VALID = 1'b0;
      @(posedge clk); #1;
      chk_eq("idle_ready", {31'd0, lsu_READY}, 32'd0);
      chk_eq("idle_req", {31'd0, mem_req}, 32'd0);
   endtask

   logic [31:0] r_ld, r_wd, r_ad;
   logic [3:0]  r_be;

   initial begin
      rst = 1'b1; lsu_VALID = 1'b0; st_mem = 1'b0; funct3 = 3'b010; addr = 32'd0;
      st_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_ready", {31'd0, lsu_READY}, 32'd0);
      chk_eq("rst_req", {31'd0, mem_req}, 32'd0);
      chk_eq("rst_bus", {mem_we, mem_be, misaligned, bus_err, 25'd0}, 32'd0);
      chk_eq("rst_addr", mem_addr | mem_wdata | ld_data, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_access(1'b0, 3'b010, 32'h100, 32'd0, 1, 32'hDEADBEEF, r_ld, r_be, r_wd, r_ad);
      chk_eq("lw_ld", r_ld, 32'hDEADBEEF);
      chk_eq("lw_be", {28'd0, r_be}, 32'hF);
      chk_eq("lw_addr", r_ad, 32'h100);
      run_access(1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h80FFFFFF, r_ld, r_be, r_wd, r_ad);
      chk_eq("lb_ld", r_ld, 32'hFFFFFF80);
      chk_eq("lb_be", {28'd0, r_be}, 32'h8);
      run_access(1'b0, 3'b100, 32'h103, 32'd0, 2, 32'h80FFFFFF, r_ld, r_be, r_wd, r_ad);
      chk_eq("lbu_ld", r_ld, 32'h00000080);
      run_access(1'b0, 3'b101, 32'h102, 32'd0, 3, 32'h80FFFFFF, r_ld, r_be, r_wd, r_ad);
      chk_eq("lhu_ld", r_ld, 32'h000080FF);
      run_access(1'b1, 3'b000, 32'h201, 32'h12345678, 1, 32'd0, r_ld, r_be, r_wd, r_ad);
      chk_eq("sb_be", {28'd0, r_be}, 32'h2);
      chk_eq("sb_wd", r_wd, 32'h78787878);
      chk_eq("sb_addr", r_ad, 32'h200);
      run_access(1'b1, 3'b001, 32'h202, 32'h12345678, 1, 32'd0, r_ld, r_be, r_wd, r_ad);
      chk_eq("sh_be", {28'd0, r_be}, 32'hC);
      chk_eq("sh_wd", r_wd, 32'h56785678);
      run_access(1'b1, 3'b010, 32'h302, 32'h1, 1, 32'd0, r_ld, r_be, r_wd, r_ad);
      run_access(1'b0, 3'b010, 32'h400, 32'd0, 0, 32'd0, r_ld, r_be, r_wd, r_ad);
      chk_eq("tmo_ld", r_ld, 32'd0);

      // Reset in cycle 2 of an access whose ack would come in cycle 5
      lsu_VALID = 1'b1; st_mem = 1'b0; funct3 = 3'b010; addr = 32'h500;
      @(posedge clk); #1;
      chk_eq("rr_req1", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; lsu_VALID = 1'b0;
      chk_eq("rr_req_low", {31'd0, mem_req}, 32'd0);
      for (int c = 4; c <= 6; c++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         chk_eq("rr_ready", {31'd0, lsu_READY}, 32'd0);
         chk_eq("rr_req", {31'd0, mem_req}, 32'd0);
         if (c == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
         end
      end
      run_access(1'b0, 3'b010, 32'h600, 32'd0, 1, 32'hCAFEF00D, r_ld, r_be, r_wd, r_ad);
      chk_eq("rr_lw_ld", r_ld, 32'hCAFEF00D);

      for (int i = 0; i < 200; i++) begin
         logic [31:0] ra = $urandom;
         run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                    $urandom_range(0, TMO + 1), $urandom, r_ld, r_be, r_wd, r_ad);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
